// File: rtl/buff_ip_to_nn_pp_pkg.sv
// Shared types for the double-buffered RX -> NN image buffer.
// Optional feature macro used by the top level: BUFF_DROP_CNT_EN.
package buff_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [0:31] ip;
    logic [0:47] mac;
    logic [0:15] udp;
  } frame_meta_t;

  // Zero-extend a pixel and scale it into the fixed-point word domain.
  function automatic logic [63:0] pix_to_word(input logic [31:0] pix, input int shift);
    return {32'd0, pix} << shift;
  endfunction

endpackage

// File: rtl/buff_ip_to_nn_pp_bank_ram.sv
// Two-bank pixel store: simple dual-port RAM, bank select is the address MSB,
// one-cycle registered read.
module buff_bank_ram #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk_i,
  input  logic                 wr_en_i,
  input  logic [ADDR_BITS:0]   wr_addr_i,
  input  logic [DATA_BITS-1:0] wr_data_i,
  input  logic                 rd_en_i,
  input  logic [ADDR_BITS:0]   rd_addr_i,
  output logic [DATA_BITS-1:0] rd_data_o
);

  logic [DATA_BITS-1:0] mem_q [0:(2**(ADDR_BITS+1))-1];
  logic [DATA_BITS-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/buff_ip_to_nn_pp.sv
// Double-buffered RX -> NN image buffer: two frame banks filled from UDP payload
// and streamed oldest-first as {row,col}-addressed words. Macro: BUFF_DROP_CNT_EN.
module buff_ip_to_nn_pp
  import buff_pkg::*;
#(
  parameter int IMG_ROWS   = 28,
  parameter int IMG_COLS   = 28,
  parameter int PIX_BITS   = 8,
  parameter int W_BITS     = 18,
  parameter int FRAC_SHIFT = 2,
  parameter int ADDR_BITS  = 10,
  parameter int RC_BITS    = 5
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [PIX_BITS-1:0]        RX_DATA,
  input  logic [ADDR_BITS-1:0]       RX_ADDR,
  input  logic                       RX_EN,
  input  logic                       FRAME_READY,
  input  logic [0:31]                SRC_IP_ADDRESS_IP,
  input  logic [0:47]                SRC_MAC_ADDRESS_IP,
  input  logic [0:15]                SRC_UDP_PORT_IP,
  input  logic                       NN_READY,
  output logic                       RX_BANK_FREE,
  output logic                       FRAME_DROP,
  output logic [0:31]                SRC_IP_ADDRESS_NN,
  output logic [0:47]                SRC_MAC_ADDRESS_NN,
  output logic [0:15]                SRC_UDP_PORT_NN,
  output logic signed [W_BITS-1:0]   W_DATA,
  output logic                       W_EN,
  output logic [2*RC_BITS-1:0]       W_ADDR,
`ifdef BUFF_DROP_CNT_EN
  output logic [15:0]                DROP_CNT,
`endif
  output logic                       W_DONE
);

  localparam int                   N_PIX    = IMG_ROWS * IMG_COLS;
  localparam logic [ADDR_BITS:0]   N_PIX_W  = (ADDR_BITS+1)'(N_PIX);
  localparam logic [ADDR_BITS-1:0] LAST_PIX = ADDR_BITS'(N_PIX - 1);
  localparam logic [RC_BITS-1:0]   LAST_COL = RC_BITS'(IMG_COLS - 1);

  state_t                state_q, state_d;
  logic [1:0]            full_q, full_d, full_af;
  logic                  rx_bank_q, rx_bank_d, rx_eff;
  logic                  tx_bank_q, tx_bank_d;
  logic [ADDR_BITS-1:0]  pix_idx_q, pix_idx_d;
  logic [RC_BITS-1:0]    row_q, row_d, col_q, col_d;
  logic                  issue, load_meta, accept;
  logic                  w_en_q, drop_q;
  logic [2*RC_BITS-1:0]  w_addr_q;
  frame_meta_t           meta_q [2];
  frame_meta_t           meta_out_q, meta_in;
  logic                  ram_wr_en;
  logic [PIX_BITS-1:0]   ram_rd_data;

  assign meta_in = '{ip: SRC_IP_ADDRESS_IP, mac: SRC_MAC_ADDRESS_IP, udp: SRC_UDP_PORT_IP};

  // Bank bookkeeping. A bank freed in DONE is released before FRAME_READY is
  // judged, and rx_bank always moves to an empty bank if one exists.
  always_comb begin
    full_af = full_q;
    if (state_q == DONE) begin
      full_af[tx_bank_q] = 1'b0;
    end
    rx_eff = rx_bank_q;
    if (full_af[rx_bank_q] && !full_af[~rx_bank_q]) begin
      rx_eff = ~rx_bank_q;
    end
    accept = FRAME_READY && !full_af[rx_eff];
    full_d = full_af;
    if (accept) begin
      full_d[rx_eff] = 1'b1;
    end
    rx_bank_d = rx_eff;
    if (full_d[rx_eff] && !full_d[~rx_eff]) begin
      rx_bank_d = ~rx_eff;
    end
    tx_bank_d = (state_q == DONE) ? ~tx_bank_q : tx_bank_q;
  end

  always_comb begin
    state_d   = state_q;
    pix_idx_d = pix_idx_q;
    row_d     = row_q;
    col_d     = col_q;
    issue     = 1'b0;
    load_meta = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_q[tx_bank_q] && NN_READY) begin
          state_d   = STREAM;
          load_meta = 1'b1;
        end
      end
      STREAM: begin
        if (NN_READY) begin
          issue = 1'b1;
          if (pix_idx_q == LAST_PIX) begin
            state_d = DRAIN;
          end else begin
            pix_idx_d = pix_idx_q + 1'b1;
            if (col_q == LAST_COL) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        state_d   = IDLE;
        pix_idx_d = '0;
        row_d     = '0;
        col_d     = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q    <= IDLE;
      full_q     <= 2'b00;
      rx_bank_q  <= 1'b0;
      tx_bank_q  <= 1'b0;
      pix_idx_q  <= '0;
      row_q      <= '0;
      col_q      <= '0;
      w_en_q     <= 1'b0;
      w_addr_q   <= '0;
      drop_q     <= 1'b0;
      meta_q[0]  <= '0;
      meta_q[1]  <= '0;
      meta_out_q <= '0;
    end else begin
      state_q   <= state_d;
      full_q    <= full_d;
      rx_bank_q <= rx_bank_d;
      tx_bank_q <= tx_bank_d;
      pix_idx_q <= pix_idx_d;
      row_q     <= row_d;
      col_q     <= col_d;
      w_en_q    <= issue;
      drop_q    <= FRAME_READY && !accept;
      if (issue) begin
        w_addr_q <= {row_q, col_q};
      end
      if (accept) begin
        meta_q[rx_eff] <= meta_in;
      end
      if (load_meta) begin
        meta_out_q <= meta_q[tx_bank_q];
      end
    end
  end

`ifdef BUFF_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      drop_cnt_q <= '0;
    end else if (FRAME_READY && !accept && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign DROP_CNT = drop_cnt_q;
`endif

  // Writes land in the bank that is filling now, even alongside FRAME_READY.
  assign ram_wr_en = RX_EN && RX_BANK_FREE && ({1'b0, RX_ADDR} < N_PIX_W);

  buff_bank_ram #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (PIX_BITS)
  ) u_ram (
    .clk_i     (ACLK),
    .wr_en_i   (ram_wr_en),
    .wr_addr_i ({rx_bank_q, RX_ADDR}),
    .wr_data_i (RX_DATA),
    .rd_en_i   (issue),
    .rd_addr_i ({tx_bank_q, pix_idx_q}),
    .rd_data_o (ram_rd_data)
  );

  assign RX_BANK_FREE       = !full_q[rx_bank_q];
  assign FRAME_DROP         = drop_q;
  assign SRC_IP_ADDRESS_NN  = meta_out_q.ip;
  assign SRC_MAC_ADDRESS_NN = meta_out_q.mac;
  assign SRC_UDP_PORT_NN    = meta_out_q.udp;
  assign W_EN               = w_en_q;
  assign W_ADDR             = w_addr_q;
  assign W_DONE             = (state_q == DONE);
  // The RAM output is not reset, so the word is forced to zero between beats.
  assign W_DATA = w_en_q ? $signed(W_BITS'(pix_to_word(32'(ram_rd_data), FRAC_SHIFT))) : '0;

endmodule

// File: tb/tb_buff_ip_to_nn_pp.sv
// Self-checking bench for buff_ip_to_nn_pp: frame-level scoreboard plus
// directed single/overlap/overflow/backpressure/reset/boundary sequences.
module tb_buff_ip_to_nn_pp;

  localparam int ROWS = 28;
  localparam int COLS = 28;
  localparam int NPIX = ROWS * COLS;

  logic               clk = 1'b0;
  logic               areset;
  logic [7:0]         rx_data;
  logic [9:0]         rx_addr;
  logic               rx_en;
  logic               frame_ready;
  logic [0:31]        src_ip_i;
  logic [0:47]        src_mac_i;
  logic [0:15]        src_udp_i;
  logic               nn_ready;
  logic               rx_bank_free;
  logic               frame_drop;
  logic [0:31]        src_ip_nn;
  logic [0:47]        src_mac_nn;
  logic [0:15]        src_udp_nn;
  logic signed [17:0] w_data;
  logic               w_en;
  logic [9:0]         w_addr;
  logic               w_done;
`ifdef BUFF_DROP_CNT_EN
  logic [15:0]        drop_cnt;
`endif

  always #5 clk = ~clk;

  buff_ip_to_nn_pp dut (
    .ACLK               (clk),
    .ARESET             (areset),
    .RX_DATA            (rx_data),
    .RX_ADDR            (rx_addr),
    .RX_EN              (rx_en),
    .FRAME_READY        (frame_ready),
    .SRC_IP_ADDRESS_IP  (src_ip_i),
    .SRC_MAC_ADDRESS_IP (src_mac_i),
    .SRC_UDP_PORT_IP    (src_udp_i),
    .NN_READY           (nn_ready),
    .RX_BANK_FREE       (rx_bank_free),
    .FRAME_DROP         (frame_drop),
    .SRC_IP_ADDRESS_NN  (src_ip_nn),
    .SRC_MAC_ADDRESS_NN (src_mac_nn),
    .SRC_UDP_PORT_NN    (src_udp_nn),
    .W_DATA             (w_data),
    .W_EN               (w_en),
    .W_ADDR             (w_addr),
`ifdef BUFF_DROP_CNT_EN
    .DROP_CNT           (drop_cnt),
`endif
    .W_DONE             (w_done)
  );

  int vec_cnt  = 0;
  int miss_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  // Entry: {last_beat, ip[32], udp[16], row[5], col[5], word[18]}
  logic [76:0] exp_q[$];
  logic [76:0] mon_e;
  logic [7:0]  cur_pix [NPIX];
  logic [17:0] obs_data [NPIX];
  int          held = 0;
  bit          drop_exp = 0, done_exp = 0, done_now = 0, nn_prev = 0, chk_en = 0;
  int          beat_total = 0, done_seen = 0, drop_seen = 0, run_len = 0, last_run = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rx_bank_free", rx_bank_free, held < 2);
      chk("frame_drop", frame_drop, drop_exp);
      chk("w_done", w_done, done_exp);
      done_now = done_exp;
      done_exp = 0;
      drop_exp = 0;
      if (frame_drop) drop_seen++;
      if (w_done) begin
        done_seen++;
        last_run = run_len;
      end
      if (w_en) begin
        chk("w_en_after_stall", nn_prev, 1'b1);
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", w_en, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat", {src_ip_nn, src_udp_nn, w_addr, w_data}, mon_e[75:0]);
          if (mon_e[76]) done_exp = 1;
        end
        if (w_addr[9:5] < ROWS && w_addr[4:0] < COLS)
          obs_data[int'(w_addr[9:5]) * COLS + int'(w_addr[4:0])] = w_data;
        beat_total++;
        run_len++;
      end else begin
        run_len = 0;
      end
      nn_prev = nn_ready;
      if (areset) begin
        exp_q.delete();
        held     = 0;
        done_exp = 0;
        drop_exp = 0;
      end else begin
        if (rx_en && rx_addr < NPIX && held < 2) cur_pix[rx_addr] = rx_data;
        if (done_now) held--;
        if (frame_ready) begin
          if (held < 2) begin
            held++;
            for (int i = 0; i < NPIX; i++) begin
              mon_e = {(i == NPIX - 1), src_ip_i, src_udp_i, 5'(i / COLS), 5'(i % COLS),
                       (18'(cur_pix[i]) << 2)};
              exp_q.push_back(mon_e);
            end
          end else begin
            drop_exp = 1;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [7:0] frame_buf [NPIX];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    areset = 1'b1;
    tick();
    tick();
    areset = 1'b0;
  endtask

  task automatic write_pix(input logic [9:0] a, input logic [7:0] d);
    rx_en   = 1'b1;
    rx_addr = a;
    rx_data = d;
    tick();
    rx_en   = 1'b0;
  endtask

  task automatic write_frame();
    for (int i = 0; i < NPIX; i++) begin
      rx_en   = 1'b1;
      rx_addr = 10'(i);
      rx_data = frame_buf[i];
      tick();
    end
    rx_en = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < NPIX; i++) frame_buf[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic send_ready(input logic [31:0] ip, input logic [47:0] mac, input logic [15:0] udp);
    src_ip_i    = ip;
    src_mac_i   = mac;
    src_udp_i   = udp;
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_seen < target && n < budget) begin
      tick();
      n++;
    end
    chk("done_timeout", done_seen >= target, 1'b1);
  endtask

  typedef struct {
    logic [9:0]  rx_addr;
    logic [7:0]  rx_data;
    logic [4:0]  exp_row;
    logic [4:0]  exp_col;
    logic [17:0] exp_word;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int base, d0, n;

    vecs[0] = '{10'd0,   8'hFF, 5'd0,  5'd0,  18'h003FC};
    vecs[1] = '{10'd27,  8'h80, 5'd0,  5'd27, 18'h00200};
    vecs[2] = '{10'd28,  8'h01, 5'd1,  5'd0,  18'h00004};
    vecs[3] = '{10'd400, 8'h00, 5'd14, 5'd8,  18'h00000};
    vecs[4] = '{10'd783, 8'h7F, 5'd27, 5'd27, 18'h001FC};
    vecs[5] = '{10'd500, 8'hF4, 5'd17, 5'd24, 18'h003D0};

    areset = 1'b1; rx_data = '0; rx_addr = '0; rx_en = 1'b0; frame_ready = 1'b0;
    src_ip_i = '0; src_mac_i = '0; src_udp_i = '0; nn_ready = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_w_en", w_en, 1'b0);
    chk("rst_w_done", w_done, 1'b0);
    chk("rst_w_data", w_data, 18'd0);
    chk("rst_w_addr", w_addr, 10'd0);
    chk("rst_frame_drop", frame_drop, 1'b0);
    chk("rst_rx_bank_free", rx_bank_free, 1'b1);
    chk("rst_src_ip", src_ip_nn, 32'd0);
    chk_en = 1;
    tick();
    areset = 1'b0;

    // Single frame, pixel = idx & 0xFF with table overrides
    for (int i = 0; i < NPIX; i++) frame_buf[i] = 8'(i & 255);
    foreach (vecs[k]) frame_buf[vecs[k].rx_addr] = vecs[k].rx_data;
    write_frame();
    send_ready(32'hC0A80001, 48'h0011_2233_4455, 16'd5000);
    nn_ready = 1'b1;
    wait_done(1, 2000);
    chk("consecutive_w_en_run", last_run, 784);
    foreach (vecs[k])
      chk("table_word", obs_data[int'(vecs[k].exp_row) * COLS + int'(vecs[k].exp_col)], vecs[k].exp_word);

    // Overlap: B received while A streams
    base = done_seen;
    d0   = drop_seen;
    fill_random();
    write_frame();
    send_ready(32'h0A000001, 48'hAAAA_0000_0001, 16'd1111);
    fill_random();
    write_frame();
    send_ready(32'h0A000002, 48'hAAAA_0000_0002, 16'd2222);
    wait_done(base + 2, 4000);
    chk("overlap_no_drop", drop_seen - d0, 0);
    chk("overlap_ip_b", src_ip_nn, 32'h0A000002);
    chk("overlap_mac_b", src_mac_nn, 48'hAAAA_0000_0002);

    // Overflow: three frames with the consumer stalled
    do_reset();
    nn_ready = 1'b0;
    fill_random();
    write_frame();
    send_ready(32'h01010101, 48'h1, 16'd1);
    fill_random();
    write_frame();
    send_ready(32'h02020202, 48'h2, 16'd2);
    @(negedge clk);
    chk("ovf_bank_free_low", rx_bank_free, 1'b0);
    tick();
    fill_random();
    write_frame();
    send_ready(32'h03030303, 48'h3, 16'd3);
    @(negedge clk);
    chk("ovf_frame_drop", frame_drop, 1'b1);
`ifdef BUFF_DROP_CNT_EN
    tick();
    @(negedge clk);
    chk("ovf_drop_cnt", drop_cnt, 16'd1);
`endif
    tick();
    base = done_seen;
    nn_ready = 1'b1;
    wait_done(base + 2, 4000);

    // Backpressure: NN_READY toggles 1,0 every cycle
    nn_ready = 1'b0;
    fill_random();
    write_frame();
    send_ready(32'h0B0B0B0B, 48'hB, 16'd11);
    base = done_seen;
    d0   = beat_total;
    nn_ready = 1'b1;
    n = 0;
    while (done_seen < base + 1 && n < 4000) begin
      tick();
      nn_ready = ~nn_ready;
      n++;
    end
    chk("bp_done", done_seen, base + 1);
    chk("bp_beat_count", beat_total - d0, 784);

    // Random consumer stalls
    fill_random();
    write_frame();
    send_ready($urandom, {$urandom, 16'($urandom)}, 16'($urandom));
    base = done_seen;
    n = 0;
    while (done_seen < base + 1 && n < 5000) begin
      nn_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("rand_done", done_seen, base + 1);

    // Reset mid-stream at pixel 300
    nn_ready = 1'b0;
    fill_random();
    write_frame();
    send_ready(32'h0C0C0C0C, 48'hC, 16'd12);
    d0 = beat_total;
    nn_ready = 1'b1;
    n = 0;
    while (beat_total - d0 < 300 && n < 2000) begin
      tick();
      n++;
    end
    chk("rst_mid_reached", beat_total - d0 >= 300, 1'b1);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    @(negedge clk);
    chk("rst_mid_w_en", w_en, 1'b0);
    chk("rst_mid_bank_free", rx_bank_free, 1'b1);
    base = done_seen;
    repeat (20) tick();
    chk("rst_mid_no_done", done_seen, base);
    fill_random();
    write_frame();
    send_ready(32'h0D0D0D0D, 48'hD, 16'd13);
    wait_done(base + 1, 2000);

    // Boundary: out-of-range writes must not disturb the frame
    fill_random();
    write_frame();
    write_pix(10'd784, 8'hAA);
    write_pix(10'd1023, 8'h55);
    send_ready(32'h0E0E0E0E, 48'hE, 16'd14);
    base = done_seen;
    wait_done(base + 1, 2000);
    repeat (4) tick();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
